data_mem_resp: RTL and testbench

Data-memory responder on the CPU's MEM-stage interface: dataAddress, writeMemData, memRead, memWrite, memMode in; readMemData out. Provides a word-organised little-endian RAM with byte/half/word access, sign/zero extension, alignment checking and a sticky fault record. Reads are combinational, so the CPU's MEM/WB register samples the data at the next edge. Writes commit on the clock edge.

---
 rtl/data_mem_resp_pkg.sv | 41 ++++
 rtl/mem_lane_align.sv | 58 +++++
 rtl/data_mem_resp.sv | 129 ++++++++++++
 tb/tb_data_mem_resp.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_resp_pkg.sv
// ============================================================================
// Module : data_mem_resp_pkg
// Brief  : Shared ISA definitions for the data-memory responder.
//          It holds the memory-mode encodings, the MMIO window offsets and an alignment helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef MMD
`define MMD 3
`endif
`ifndef WORD
`define WORD 32
`endif

package data_mem_resp_pkg;

  typedef logic [`MMD-1:0] mem_mode_t;

  localparam mem_mode_t MMD_W  = mem_mode_t'(0);
  localparam mem_mode_t MMD_H  = mem_mode_t'(1);
  localparam mem_mode_t MMD_HU = mem_mode_t'(2);
  localparam mem_mode_t MMD_B  = mem_mode_t'(3);
  localparam mem_mode_t MMD_BU = mem_mode_t'(4);

  localparam logic [3:0] MMIO_OFF_LED  = 4'h0;
  localparam logic [3:0] MMIO_OFF_CNT  = 4'h4;
  localparam logic [3:0] MMIO_OFF_STAT = 4'h8;

  // Undefined encodings are word accesses, so they need a word-aligned lane.
  function automatic logic lane_aligned(input mem_mode_t mode, input logic [1:0] lane);
    case (mode)
      MMD_H, MMD_HU: return ~lane[0];
      MMD_B, MMD_BU: return 1'b1;
      default:       return (lane == 2'b00);
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
// Module : mem_lane_align
// Brief  : Little-endian lane logic. It builds the byte enables, the merge for
//          stores and the extraction plus sign or zero extension for loads.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_lane_align
  import data_mem_resp_pkg::*;
(
  input  logic [`MMD-1:0]  mode,
  input  logic [1:0]       lane,
  input  logic [`WORD-1:0] wdata,
  input  logic [`WORD-1:0] rword,
  output logic             aligned,
  output logic [3:0]       byte_en,
  output logic [`WORD-1:0] wmerged,
  output logic [`WORD-1:0] rdata
);

  logic [`WORD-1:0] wrep;
  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;

  always_comb begin
    aligned  = lane_aligned(mode, lane);
    sel_byte = rword[8*lane +: 8];
    sel_half = lane[1] ? rword[31:16] : rword[15:0];
    byte_en  = 4'b1111;
    wrep     = wdata;
    rdata    = rword;
    case (mode)
      MMD_B, MMD_BU: begin
        byte_en = 4'b0001 << lane;
        wrep    = {4{wdata[7:0]}};
        rdata   = (mode == MMD_B) ? {{24{sel_byte[7]}}, sel_byte} : {24'b0, sel_byte};
      end
      MMD_H, MMD_HU: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wrep    = {2{wdata[15:0]}};
        rdata   = (mode == MMD_H) ? {{16{sel_half[15]}}, sel_half} : {16'b0, sel_half};
      end
      default: begin
        byte_en = 4'b1111;
      end
    endcase
  end

  generate
    for (genvar i = 0; i < 4; i++) begin : g_lane
      assign wmerged[8*i +: 8] = byte_en[i] ? wrep[8*i +: 8] : rword[8*i +: 8];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/data_mem_resp.sv
// ============================================================================
// Module : data_mem_resp
// Brief  : MEM-stage data RAM. Loads are combinational, stores commit on the edge,
//          and the first misaligned access is held in a sticky fault record.
//          The optional MMIO window is enabled with DATA_MEM_MMIO_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [`WORD-1:0] dataAddress,
  input  logic [`WORD-1:0] writeMemData,
  input  logic             memRead,
  input  logic             memWrite,
  input  logic [`MMD-1:0]  memMode,
  output logic [`WORD-1:0] readMemData,
  output logic [`WORD-1:0] ledOut,
  output logic             misalign,
  output logic [`WORD-1:0] faultAddr
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [`WORD-1:0] ram [DEPTH_WORDS];
  logic [AW-1:0]    idx;
  logic [`WORD-1:0] rword, wmerged, ram_rdata, mmio_rdata;
  logic [3:0]       byte_en_unused;
  logic             lane_ok, access_ok, ram_hit, clear, fault, ram_we;
  logic             misalign_q, misalign_d;
  logic [`WORD-1:0] fault_addr_q, fault_addr_d;

  assign idx   = dataAddress[AW+1:2];
  assign rword = ram[idx];

  mem_lane_align u_align (
    .mode    (memMode),
    .lane    (dataAddress[1:0]),
    .wdata   (writeMemData),
    .rword   (rword),
    .aligned (lane_ok),
    .byte_en (byte_en_unused),
    .wmerged (wmerged),
    .rdata   (ram_rdata)
  );

`ifdef DATA_MEM_MMIO_EN
  logic             in_win;
  logic [3:0]       mmio_off;
  logic [`WORD-1:0] led_q, led_d, cyc_q, cyc_d;

  assign in_win   = (dataAddress[31:4] == MMIO_BASE[31:4]);
  assign mmio_off = dataAddress[3:0];

  // The window is word-only, so any narrow mode there is a fault.
  always_comb begin
    access_ok = in_win ? (lane_ok && !(memMode inside {MMD_H, MMD_HU, MMD_B, MMD_BU})) : lane_ok;
    ram_hit   = !in_win;
    clear     = memWrite && in_win && access_ok && (mmio_off == MMIO_OFF_STAT);
    led_d     = (memWrite && in_win && access_ok && (mmio_off == MMIO_OFF_LED)) ? writeMemData : led_q;
    cyc_d     = cyc_q + 32'd1;
    case (mmio_off)
      MMIO_OFF_LED:  mmio_rdata = led_q;
      MMIO_OFF_CNT:  mmio_rdata = cyc_q;
      MMIO_OFF_STAT: mmio_rdata = {31'b0, misalign_q};
      default:       mmio_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= '0;
      cyc_q <= '0;
    end else begin
      led_q <= led_d;
      cyc_q <= cyc_d;
    end
  end

  assign ledOut = led_q;
`else
  logic unused_hi;

  always_comb begin
    access_ok  = lane_ok;
    ram_hit    = 1'b1;
    clear      = 1'b0;
    mmio_rdata = '0;
  end

  assign unused_hi = ^{MMIO_BASE, dataAddress[`WORD-1:AW+2]};
  assign ledOut    = '0;
`endif

  always_comb begin
    fault        = (memRead || memWrite) && !access_ok;
    ram_we       = memWrite && access_ok && ram_hit && rst_n;
    readMemData  = (!memRead || !access_ok) ? '0 : (ram_hit ? ram_rdata : mmio_rdata);
    misalign_d   = clear ? 1'b0 : (misalign_q || fault);
    fault_addr_d = clear ? '0 : ((fault && !misalign_q) ? dataAddress : fault_addr_q);
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram[idx] <= wmerged;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q   <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      misalign_q   <= misalign_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign misalign  = misalign_q;
  assign faultAddr = fault_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_resp.sv
// ============================================================================
// Module : tb_data_mem_resp
// Brief  : Self-checking bench for data_mem_resp. It uses a vector table, hand-written
//          corner sequences and randomized traffic against a byte-array model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_data_mem_resp;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] MBASE = 32'hFFFF_0000;
  localparam logic [2:0]  W = 3'd0, H = 3'd1, HU = 3'd2, B = 3'd3, BU = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] dataAddress = '0, writeMemData = '0;
  logic        memRead = 1'b0, memWrite = 1'b0;
  logic [2:0]  memMode = '0;
  logic [31:0] readMemData, ledOut, faultAddr;
  logic        misalign;

  data_mem_resp #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(MBASE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dataAddress  (dataAddress),
    .writeMemData (writeMemData),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .memMode      (memMode),
    .readMemData  (readMemData),
    .ledOut       (ledOut),
    .misalign     (misalign),
    .faultAddr    (faultAddr)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  mdl [DEPTH*4];
  logic        m_mis = 1'b0;
  logic [31:0] m_fa = '0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        rd;
    logic        wr;
    logic [2:0]  mode;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic m_aligned(input logic [2:0] mode, input logic [31:0] a);
    if (mode == H || mode == HU) return (a % 2) == 0;
    if (mode == B || mode == BU) return 1'b1;
    return (a % 4) == 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] mode, input logic [31:0] a);
    int base, off, v;
    base = int'((a / 4) % DEPTH) * 4;
    off  = int'(a % 4);
    v    = 0;
    case (mode)
      B, BU: begin
        v = int'(mdl[base+off]);
        if (mode == B && v > 127) v -= 256;
      end
      H, HU: begin
        v = int'(mdl[base+off]) + 256 * int'(mdl[base+off+1]);
        if (mode == H && v > 32767) v -= 65536;
      end
      default: return {mdl[base+3], mdl[base+2], mdl[base+1], mdl[base]};
    endcase
    return 32'(v);
  endfunction

  function automatic void m_store(input logic [2:0] mode, input logic [31:0] a, input logic [31:0] d);
    int base, off;
    base = int'((a / 4) % DEPTH) * 4;
    off  = int'(a % 4);
    case (mode)
      B, BU: mdl[base+off] = d[7:0];
      H, HU: begin
        mdl[base+off]   = d[7:0];
        mdl[base+off+1] = d[15:8];
      end
      default: for (int k = 0; k < 4; k++) mdl[base+k] = d[8*k +: 8];
    endcase
  endfunction

  // One bus cycle: drive, sample the combinational load, take the edge, update the model.
  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic rd,
                        input logic wr, input logic [2:0] mode, output logic [31:0] got);
    logic ok;
    dataAddress  = a;
    writeMemData = d;
    memRead      = rd;
    memWrite     = wr;
    memMode      = mode;
    #2;
    got = readMemData;
    @(posedge clk);
    #1;
    ok = m_aligned(mode, a);
    if ((rd || wr) && !ok && !m_mis) begin
      m_mis = 1'b1;
      m_fa  = a;
    end
    if (wr && ok) m_store(mode, a, d);
    memRead  = 1'b0;
    memWrite = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    m_mis = 1'b0;
    m_fa  = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [18];
    logic [31:0] got, got2, exp, a, d;
    logic [2:0]  mode;
    logic        rd, wr;
    int          r;

    tbl[0]  = '{32'h10, 32'h8081_8283, 0, 1, W,    32'h0};
    tbl[1]  = '{32'h11, 32'h0,         1, 0, B,    32'hFFFF_FF82};
    tbl[2]  = '{32'h11, 32'h0,         1, 0, BU,   32'h0000_0082};
    tbl[3]  = '{32'h12, 32'h0,         1, 0, H,    32'hFFFF_8081};
    tbl[4]  = '{32'h12, 32'h0,         1, 0, HU,   32'h0000_8081};
    tbl[5]  = '{32'h20, 32'h1122_3344, 0, 1, W,    32'h0};
    tbl[6]  = '{32'h23, 32'h1234_56AA, 0, 1, B,    32'h0};
    tbl[7]  = '{32'h20, 32'h0,         1, 0, W,    32'hAA22_3344};
    tbl[8]  = '{32'h24, 32'h0,         0, 1, W,    32'h0};
    tbl[9]  = '{32'h26, 32'hBEEF_1234, 0, 1, H,    32'h0};
    tbl[10] = '{32'h24, 32'h0,         1, 0, W,    32'h1234_0000};
    tbl[11] = '{32'h60, 32'hA5A5_A5A5, 0, 1, W,    32'h0};
    tbl[12] = '{32'h60, 32'h5A5A_0000, 1, 1, W,    32'hA5A5_A5A5};
    tbl[13] = '{32'h60, 32'h0,         1, 0, W,    32'h5A5A_0000};
    tbl[14] = '{32'h10, 32'h0,         1, 0, 3'd7, 32'h8081_8283};
    tbl[15] = '{32'h13, 32'h0,         1, 0, B,    32'hFFFF_FF80};
    tbl[16] = '{32'h10, 32'h0,         1, 0, BU,   32'h0000_0083};
    tbl[17] = '{32'h10, 32'h0,         0, 0, W,    32'h0};

    #1 rst_n = 1'b0;
    #9;
    chk("reset_misalign", {31'b0, misalign}, 32'h0);
    chk("reset_faultAddr", faultAddr, 32'h0);
    chk("reset_ledOut", ledOut, 32'h0);
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      access(tbl[i].a, tbl[i].d, tbl[i].rd, tbl[i].wr, tbl[i].mode, got);
      chk($sformatf("vec%0d_rdata", i), got, tbl[i].exp);
    end
    chk("vec_misalign", {31'b0, misalign}, 32'h0);

    // A misaligned half store is dropped, and the first fault address sticks.
    access(32'h30, 32'hDEAD_BEEF, 0, 1, W, got);
    access(32'h31, 32'h0000_1234, 0, 1, H, got);
    chk("mis_store_flag", {31'b0, misalign}, 32'h1);
    chk("mis_store_addr", faultAddr, 32'h31);
    access(32'h30, 32'h0, 1, 0, W, got);
    chk("mis_store_ram", got, 32'hDEAD_BEEF);
    access(32'h42, 32'h0, 1, 0, W, got);
    chk("mis_load_zero", got, 32'h0);
    chk("mis_first_kept", faultAddr, 32'h31);

    access(32'h0, 32'hCAFE_F00D, 0, 1, W, got);
    access(32'h0, 32'h0, 1, 0, W, got);
    access(DEPTH * 4, 32'h0, 1, 0, W, got2);
    chk("wrap_lo", got, 32'hCAFE_F00D);
    chk("wrap_hi", got2, 32'hCAFE_F00D);

    // Asynchronous reset while a store is pending.
    access(32'h50, 32'h1111_1111, 0, 1, W, got);
    dataAddress  = 32'h50;
    writeMemData = 32'h7777_7777;
    memMode      = W;
    memWrite     = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_misalign", {31'b0, misalign}, 32'h0);
    chk("async_faultAddr", faultAddr, 32'h0);
    chk("async_ledOut", ledOut, 32'h0);
    @(posedge clk);
    #1 memWrite = 1'b0;
    #1 rst_n = 1'b1;
    m_mis = 1'b0;
    m_fa  = '0;
    @(posedge clk);
    #1;
    access(32'h50, 32'h0, 1, 0, W, got);
    chk("async_store_dropped", got, 32'h1111_1111);

`ifdef DATA_MEM_MMIO_EN
    access(MBASE, 32'h5A, 0, 1, W, got);
    chk("mmio_led", ledOut, 32'h5A);
    access(MBASE + 4, 32'h0, 1, 0, W, got);
    repeat (9) access(32'h0, 32'h0, 0, 0, W, got2);
    access(MBASE + 4, 32'h0, 1, 0, W, got2);
    chk("mmio_cnt_delta", got2 - got, 32'd10);
    access(MBASE + 1, 32'h0, 1, 0, B, got);
    chk("mmio_narrow_fault", {31'b0, misalign}, 32'h1);
    chk("mmio_narrow_addr", faultAddr, MBASE + 1);
    access(MBASE + 8, 32'h0, 0, 1, W, got);
    m_mis = 1'b0;
    m_fa  = '0;
    chk("mmio_clear_flag", {31'b0, misalign}, 32'h0);
    chk("mmio_clear_addr", faultAddr, 32'h0);
    access(MBASE + 12, 32'h0, 1, 0, W, got);
    chk("mmio_reserved", got, 32'h0);
`else
    access(MBASE, 32'h0000_005A, 0, 1, W, got);
    chk("nommio_led", ledOut, 32'h0);
    access(32'h0, 32'h0, 1, 0, W, got);
    chk("nommio_alias", got, 32'h0000_005A);
`endif

    for (int k = 0; k < DEPTH; k++) access(k * 4, $urandom, 0, 1, W, got);

    for (int round = 0; round < 4; round++) begin
      pulse_reset();
      for (int n = 0; n < 100; n++) begin
        a    = $urandom_range(0, DEPTH * 8 - 1);
        d    = $urandom;
        mode = 3'($urandom_range(0, 7));
        r    = $urandom_range(0, 3);
        rd   = (r == 0 || r == 2);
        wr   = (r == 1 || r == 2);
        exp  = (rd && m_aligned(mode, a)) ? m_load(mode, a) : 32'h0;
        access(a, d, rd, wr, mode, got);
        chk("rand_rdata", got, exp);
        chk("rand_misalign", {31'b0, misalign}, {31'b0, m_mis});
        chk("rand_faultAddr", faultAddr, m_fa);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
